// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone B3 arbiter for three masters onto one slave, with a bus watchdog.
module wb_rr_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic [3*AW-1:0]     m_adr_i,
    input  logic [3*DW-1:0]     m_dat_i,
    input  logic [3*DW/8-1:0]   m_sel_i,
    input  logic [2:0]          m_we_i,
    input  logic [2:0]          m_cyc_i,
    input  logic [2:0]          m_stb_i,
    input  logic [8:0]          m_cti_i,
    input  logic [5:0]          m_bte_i,
    output logic [DW-1:0]       m_dat_o,
    output logic [2:0]          m_ack_o,
    output logic [2:0]          m_err_o,
    output logic [2:0]          m_rty_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    output logic [DW/8-1:0]     s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic [2:0]          s_cti_o,
    output logic [1:0]          s_bte_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic                s_rty_i,
    output logic [2:0]          grant_o,
    output logic                timeout_o
);
    typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;
    state_t           r_state, w_state_n;
    logic [1:0]       r_own, r_last, w_own_n, w_last_n, w_o1, w_o2, w_pick;
    logic [CNT_W-1:0] r_wdog, w_wdog_n;
    logic             r_to, w_to_n, w_gnt, w_resp;
    logic [2:0]       w_oh;
    logic [AW-1:0]    w_adr [3];
    logic [DW-1:0]    w_dat [3];
    logic [DW/8-1:0]  w_sel [3];
    logic [2:0]       w_cti [3];
    logic [1:0]       w_bte [3];
    for (genvar i = 0; i < 3; i++) begin : g_unpack
        assign w_adr[i] = m_adr_i[i*AW +: AW];
        assign w_dat[i] = m_dat_i[i*DW +: DW];
        assign w_sel[i] = m_sel_i[i*(DW/8) +: DW/8];
        assign w_cti[i] = m_cti_i[i*3 +: 3];
        assign w_bte[i] = m_bte_i[i*2 +: 2];
    end
    // Rotation order after the last owner: last+1, last+2, then last itself.
    assign w_o1   = r_last == 2'd0 ? 2'd1 : r_last == 2'd1 ? 2'd2 : 2'd0;
    assign w_o2   = r_last == 2'd0 ? 2'd2 : r_last == 2'd1 ? 2'd0 : 2'd1;
    assign w_pick = m_cyc_i[w_o1] ? w_o1 : m_cyc_i[w_o2] ? w_o2 : r_last;
    assign w_gnt  = r_state == GRANT;
    assign w_resp = s_ack_i | s_err_i | s_rty_i;
    assign w_oh   = 3'b001 << r_own;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
            r_own   <= 2'd0;
            r_last  <= 2'd2;
            r_wdog  <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_own   <= w_own_n;
            r_last  <= w_last_n;
            r_wdog  <= w_wdog_n;
            r_to    <= w_to_n;
        end
    end
    always_comb begin
        w_state_n = r_state;
        w_own_n   = r_own;
        w_last_n  = r_last;
        w_wdog_n  = '0;
        w_to_n    = 1'b0;
        if (r_state == IDLE) begin
            if (|m_cyc_i) begin
                w_state_n = GRANT;
                w_own_n   = w_pick;
            end
        end else if (!m_cyc_i[r_own]) begin
            w_state_n = IDLE;
            w_last_n  = r_own;
        end else if (w_gnt && m_stb_i[r_own] && !w_resp) begin
            if (r_wdog == CNT_W'(TIMEOUT - 1)) begin
                w_state_n = ABORT;
                w_to_n    = 1'b1;
            end else begin
                w_wdog_n = r_wdog + 1'b1;
            end
        end
    end
    always_comb begin
        s_cyc_o   = w_gnt & m_cyc_i[r_own];
        s_stb_o   = w_gnt & m_stb_i[r_own];
        s_we_o    = w_gnt & m_we_i[r_own];
        s_adr_o   = w_gnt ? w_adr[r_own] : '0;
        s_dat_o   = w_gnt ? w_dat[r_own] : '0;
        s_sel_o   = w_gnt ? w_sel[r_own] : '0;
        s_cti_o   = w_gnt ? w_cti[r_own] : '0;
        s_bte_o   = w_gnt ? w_bte[r_own] : '0;
        m_dat_o   = s_dat_i;
        m_ack_o   = (w_gnt && s_ack_i) ? w_oh : 3'b000;
        m_err_o   = ((w_gnt && s_err_i) || (r_state == ABORT && r_to)) ? w_oh : 3'b000;
        m_rty_o   = (w_gnt && s_rty_i) ? w_oh : 3'b000;
        grant_o   = w_gnt ? w_oh : 3'b000;
        timeout_o = r_to;
    end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Wishbone B3 arbiter placed directly upstream of the main-RAM slave (wb_ram).
- Merges three masters onto that single slave: CPU instruction bus (m0), CPU data bus (m1) and the debug master (m2).
- Arbitration is round-robin, and a grant is held for the whole cycle, including registered-feedback bursts.
- A bus watchdog aborts any slave access that never responds, so a hung access cannot stall the CPU or the debugger.

Parameters:
- AW, 32, address width.
- DW, 32, data width; select width is DW/8.
- TIMEOUT, 255, number of stb-high cycles without ack/err/rty before the watchdog aborts; legal range 2..65535.
- CNT_W, 16, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- m_adr_i  in  3*AW  master addresses; master k occupies slice [k*AW +: AW].
- m_dat_i  in  3*DW  master write data.
- m_sel_i  in  3*DW/8  master byte selects.
- m_we_i  in  3  write enables.
- m_cyc_i  in  3  cycle requests.
- m_stb_i  in  3  strobes.
- m_cti_i  in  9  cycle type identifiers, 3 bits per master.
- m_bte_i  in  6  burst type extensions, 2 bits per master.
- m_dat_o  out  DW  read data, broadcast to all masters.
- m_ack_o  out  3  per-master ack.
- m_err_o  out  3  per-master err.
- m_rty_o  out  3  per-master rty.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst type.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- s_rty_i  in  1  slave rty.
- grant_o  out  3  one-hot current grant; 0 when no master holds the bus.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (asynchronous, wb_rst_ni low):
  - state=IDLE, grant=0, last=2, wdog=0, timeout_o=0.
  - All s_* outputs and all m_ack/err/rty outputs are 0 immediately, independent of the clock.
- States:
  - IDLE: no grant.
  - GRANT: one master owns the slave.
  - ABORT: watchdog has fired; waiting for the owner to drop cyc.
- IDLE:
  - s_cyc_o=s_stb_o=0; all s_* data/address/control outputs are 0.
  - On a clock edge with any m_cyc_i high, grant the first requester in the order last+1, last+2, last (mod 3), and go to GRANT.
  - Grant latency: 1 cycle from request to s_cyc_o.
  - After reset (last=2), master 0 wins a simultaneous request.
- GRANT, owner g:
  - s_* outputs are a combinational mux of master g.
  - m_dat_o = s_dat_i.
  - m_ack/err/rty_o[g] = s_ack/err/rty_i; all non-owners see 0.
  - The grant is held while m_cyc_i[g]=1, regardless of cti/bte or stb gaps, so bursts are never split.
  - When m_cyc_i[g]=0 at a clock edge: last=g and state goes to IDLE. A mandatory idle cycle follows; there is no same-cycle re-grant.
- Watchdog:
  - In GRANT, wdog increments each cycle with s_stb_o=1 and none of ack/err/rty.
  - wdog clears on any slave response, when stb is low, and on state exit.
  - When wdog == TIMEOUT-1 and there is still no response in that cycle, the next cycle:
    - state=ABORT;
    - m_err_o[g]=1 for exactly one cycle;
    - timeout_o=1 for one cycle;
    - s_cyc_o/s_stb_o=0 from that cycle onward.
- ABORT:
  - s_cyc_o=0; all m_ack/err/rty outputs are 0 after the err pulse.
  - When m_cyc_i[g]=0 at a clock edge: last=g and state goes to IDLE.
- Simultaneous events:
  - A slave response in the same cycle the counter reaches TIMEOUT-1 wins: no abort, the counter clears.
  - Owner dropping cyc in the same cycle as a late slave ack: the ack is forwarded combinationally, and the state still moves to IDLE.
- Requests that arrive from non-owners while the bus is granted are queued implicitly by their held cyc and served by rotation.
- grant_o equals the registered grant vector; it is 0 in IDLE and in ABORT.

Test Plan:
- Reset priority:
  - Stimulus: release reset; m0, m1 and m2 raise cyc on the same edge.
  - Required: grant_o=001 one cycle later; then 010, then 100 as each master drops cyc, with one idle cycle between each grant.
- Burst hold:
  - Stimulus: m1 runs an 8-beat incrementing burst (cti=010, last beat 111) while m0 requests throughout.
  - Required: s_cyc_o stays high for all 8 acks, grant_o=010 throughout; m0 is granted only after m1's cyc drops.
- Ack isolation:
  - Stimulus: m2 single read of 0x100 with the slave returning 0xDEADBEEF and ack.
  - Required: m_ack_o=100 and m_dat_o=0xDEADBEEF; m_ack_o[1:0] stays 0.
- Watchdog:
  - Stimulus: TIMEOUT=4; m1 strobes and the slave never responds.
  - Required: after 4 stb cycles, m_err_o[1] and timeout_o pulse for 1 cycle and s_cyc_o drops; after m1 drops cyc, state returns to IDLE.
- Watchdog boundary:
  - Stimulus: TIMEOUT=4; slave ack arrives on the 4th stb cycle.
  - Required: normal ack, no err, no timeout_o pulse.
- Reset mid-burst:
  - Stimulus: assert wb_rst_ni low during beat 3 of an m0 burst.
  - Required: s_cyc_o, m_ack_o and grant_o go to 0 asynchronously; after release, m0 is regranted with priority.
